// File: rtl/axis_square_stimulus_gen.sv
// Dual-channel square-wave stimulus on an AXI-Stream ADC-format bus (CH1 low half, CH2 high half).
// Optional build macro NOISE_EN adds a 16-bit LFSR dither of -4..+3 LSB to both channels.
module axis_square_stimulus_gen #(
   parameter int ADC_WIDTH        = 14,
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int COUNT_WIDTH      = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   input  logic        [COUNT_WIDTH-1:0]     period,
   input  logic        [COUNT_WIDTH-1:0]     phase_delay,
   input  logic        [COUNT_WIDTH-1:0]     burst_cycles,
   input  logic signed [ADC_WIDTH-1:0]       level_high_ch1,
   input  logic signed [ADC_WIDTH-1:0]       level_low_ch1,
   input  logic signed [ADC_WIDTH-1:0]       level_high_ch2,
   input  logic signed [ADC_WIDTH-1:0]       level_low_ch2,
   output logic        [AXIS_TDATA_WIDTH-1:0] M_AXIS_OUT_tdata,
   output logic                              M_AXIS_OUT_tvalid,
   input  logic                              M_AXIS_OUT_tready,
   output logic                              busy,
   output logic        [COUNT_WIDTH-1:0]     cycles_done
);

   localparam int HALF = AXIS_TDATA_WIDTH / 2;
   localparam int EXT  = HALF - ADC_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                        r_state, w_state_nxt;
   logic        [COUNT_WIDTH-1:0] r_ps, r_ds, r_h, r_burst, r_idx, r_cycles;
   logic signed [ADC_WIDTH-1:0]   r_hi1, r_lo1, r_hi2, r_lo2;
   logic [AXIS_TDATA_WIDTH-1:0]   r_tdata;
   logic                          r_tvalid;

   logic                          w_accept, w_last, w_burst_end;
   logic                          w_start, w_step, w_wrap, w_stop, w_reload;
   logic        [COUNT_WIDTH-1:0] w_ps_in, w_ds_in, w_h_in;
   logic        [COUNT_WIDTH-1:0] w_i, w_j, w_ps_sel, w_ds_sel, w_h_sel;
   logic signed [ADC_WIDTH-1:0]   w_hi1_sel, w_lo1_sel, w_hi2_sel, w_lo2_sel;
   logic signed [ADC_WIDTH-1:0]   w_lvl1, w_lvl2, w_ch1, w_ch2;
   logic [AXIS_TDATA_WIDTH-1:0]   w_sample;

   // Period of at least two samples so both levels appear; delay folded into one period.
   assign w_ps_in = (period < COUNT_WIDTH'(2)) ? COUNT_WIDTH'(2) : period;
   assign w_ds_in = (phase_delay >= w_ps_in) ? w_ps_in - COUNT_WIDTH'(1) : phase_delay;
   assign w_h_in  = w_ps_in >> 1;

   assign w_accept    = r_tvalid & M_AXIS_OUT_tready;
   assign w_last      = (r_idx == r_ps - COUNT_WIDTH'(1));
   assign w_burst_end = (r_burst != '0) && (r_cycles + COUNT_WIDTH'(1) == r_burst);

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_step      = 1'b0;
      w_wrap      = 1'b0;
      w_stop      = 1'b0;
      case (r_state)
         S_IDLE: if (enable) begin
            w_state_nxt = S_RUN;
            w_start     = 1'b1;
         end
         S_RUN: if (w_accept) begin
            if (w_last) begin
               w_wrap = 1'b1;
               if (w_burst_end) begin
                  w_state_nxt = S_DONE;
                  w_stop      = 1'b1;
               end else if (!enable) begin
                  w_state_nxt = S_IDLE;
                  w_stop      = 1'b1;
               end
            end else begin
               w_step = 1'b1;
            end
         end
         S_DONE: if (!enable) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Index 0 of a new period is generated from the live inputs, since the shadows load on the same edge.
   assign w_reload  = w_start | w_wrap;
   assign w_i       = w_reload ? '0 : r_idx + COUNT_WIDTH'(1);
   assign w_ps_sel  = w_reload ? w_ps_in        : r_ps;
   assign w_ds_sel  = w_reload ? w_ds_in        : r_ds;
   assign w_h_sel   = w_reload ? w_h_in         : r_h;
   assign w_hi1_sel = w_reload ? level_high_ch1 : r_hi1;
   assign w_lo1_sel = w_reload ? level_low_ch1  : r_lo1;
   assign w_hi2_sel = w_reload ? level_high_ch2 : r_hi2;
   assign w_lo2_sel = w_reload ? level_low_ch2  : r_lo2;

   assign w_j    = (w_i >= w_ds_sel) ? w_i - w_ds_sel : w_i + w_ps_sel - w_ds_sel;
   assign w_lvl1 = (w_i < w_h_sel) ? w_hi1_sel : w_lo1_sel;
   assign w_lvl2 = (w_j < w_h_sel) ? w_hi2_sel : w_lo2_sel;

`ifdef NOISE_EN
   localparam logic signed [ADC_WIDTH:0] LVL_MAX = (ADC_WIDTH+1)'(2**(ADC_WIDTH-1) - 1);
   localparam logic signed [ADC_WIDTH:0] LVL_MIN = (ADC_WIDTH+1)'(-(2**(ADC_WIDTH-1)));

   logic [15:0] r_lfsr;

   function automatic logic signed [ADC_WIDTH-1:0] f_add_sat(input logic signed [ADC_WIDTH-1:0] lvl,
                                                             input logic [2:0] n);
      logic signed [ADC_WIDTH:0] sum;
      sum = {lvl[ADC_WIDTH-1], lvl} + {{(ADC_WIDTH-2){n[2]}}, n};
      if (sum > LVL_MAX)      return LVL_MAX[ADC_WIDTH-1:0];
      else if (sum < LVL_MIN) return LVL_MIN[ADC_WIDTH-1:0];
      else                    return sum[ADC_WIDTH-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (!rst)          r_lfsr <= 16'hACE1;
      else if (w_accept) r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   end

   assign w_ch1 = f_add_sat(w_lvl1, r_lfsr[2:0]);
   assign w_ch2 = f_add_sat(w_lvl2, r_lfsr[2:0]);
`else
   assign w_ch1 = w_lvl1;
   assign w_ch2 = w_lvl2;
`endif

   assign w_sample = {{EXT{w_ch2[ADC_WIDTH-1]}}, w_ch2, {EXT{w_ch1[ADC_WIDTH-1]}}, w_ch1};

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ps     <= '0;
         r_ds     <= '0;
         r_h      <= '0;
         r_burst  <= '0;
         r_hi1    <= '0;
         r_lo1    <= '0;
         r_hi2    <= '0;
         r_lo2    <= '0;
         r_idx    <= '0;
         r_cycles <= '0;
         r_tdata  <= '0;
         r_tvalid <= 1'b0;
      end else begin
         if (w_reload) begin
            r_ps    <= w_ps_in;
            r_ds    <= w_ds_in;
            r_h     <= w_h_in;
            r_burst <= burst_cycles;
            r_hi1   <= level_high_ch1;
            r_lo1   <= level_low_ch1;
            r_hi2   <= level_high_ch2;
            r_lo2   <= level_low_ch2;
         end
         if (w_start) begin
            r_cycles <= '0;
            r_idx    <= '0;
            r_tvalid <= 1'b1;
            r_tdata  <= w_sample;
         end else if (w_wrap) begin
            r_cycles <= r_cycles + COUNT_WIDTH'(1);
            r_idx    <= '0;
            if (w_stop) r_tvalid <= 1'b0;
            else        r_tdata  <= w_sample;
         end else if (w_step) begin
            r_idx   <= w_i;
            r_tdata <= w_sample;
         end
      end
   end

   assign M_AXIS_OUT_tdata  = r_tdata;
   assign M_AXIS_OUT_tvalid = r_tvalid;
   assign busy              = (r_state == S_RUN);
   assign cycles_done       = r_cycles;

endmodule

// File: tb/tb_axis_square_stimulus_gen.sv
// Directed bench for axis_square_stimulus_gen: waveform tables, backpressure, burst, sanitising, reset abort.
module tb_axis_square_stimulus_gen;

   localparam int AW = 14;
   localparam int TW = 32;
   localparam int CW = 32;

   // Words as {CH2, CH1} with levels +1000 (0x03E8) / -1000 (0xFC18 after sign extension).
   localparam logic [31:0] W_HH   = 32'h03E8_03E8;
   localparam logic [31:0] W_LL   = 32'hFC18_FC18;
   localparam logic [31:0] W_1H2L = 32'hFC18_03E8;
   localparam logic [31:0] W_1L2H = 32'h03E8_FC18;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 enable = 1'b0;
   logic        [CW-1:0] period = '0;
   logic        [CW-1:0] phase_delay = '0;
   logic        [CW-1:0] burst_cycles = '0;
   logic signed [AW-1:0] level_high_ch1 = '0;
   logic signed [AW-1:0] level_low_ch1 = '0;
   logic signed [AW-1:0] level_high_ch2 = '0;
   logic signed [AW-1:0] level_low_ch2 = '0;
   logic        [TW-1:0] tdata;
   logic                 tvalid;
   logic                 tready = 1'b1;
   logic                 busy;
   logic        [CW-1:0] cycles_done;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_d0 [10];
   logic [31:0] exp_d3 [10];
   logic [31:0] exp_p8d7 [8];

   axis_square_stimulus_gen #(
      .ADC_WIDTH(AW),
      .AXIS_TDATA_WIDTH(TW),
      .COUNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .period(period),
      .phase_delay(phase_delay),
      .burst_cycles(burst_cycles),
      .level_high_ch1(level_high_ch1),
      .level_low_ch1(level_low_ch1),
      .level_high_ch2(level_high_ch2),
      .level_low_ch2(level_low_ch2),
      .M_AXIS_OUT_tdata(tdata),
      .M_AXIS_OUT_tvalid(tvalid),
      .M_AXIS_OUT_tready(tready),
      .busy(busy),
      .cycles_done(cycles_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 ns after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Synchronous reset for one edge with enable held high; sample 0 is on the bus on return.
   task automatic restart(input logic [CW-1:0] p, input logic [CW-1:0] d, input logic [CW-1:0] b);
      rst          = 1'b0;
      enable       = 1'b1;
      tready       = 1'b1;
      period       = p;
      phase_delay  = d;
      burst_cycles = b;
      tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      int acc;
      exp_d0   = '{W_HH, W_HH, W_HH, W_HH, W_HH, W_LL, W_LL, W_LL, W_LL, W_LL};
      exp_d3   = '{W_1H2L, W_1H2L, W_1H2L, W_HH, W_HH, W_1L2H, W_1L2H, W_1L2H, W_LL, W_LL};
      exp_p8d7 = '{W_HH, W_HH, W_HH, W_1H2L, W_LL, W_LL, W_LL, W_1L2H};

      level_high_ch1 = 14'sd1000;
      level_low_ch1  = -14'sd1000;
      level_high_ch2 = 14'sd1000;
      level_low_ch2  = -14'sd1000;
      period         = 32'd10;

      // Reset state and idle behaviour.
      tick();
      tick();
      check("rst_tvalid", tvalid, 1'b0);
      check("rst_tdata", tdata, 32'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_cycles", cycles_done, 32'd0);
      rst = 1'b1;
      tick();
      check("idle_tvalid", tvalid, 1'b0);
      check("idle_busy", busy, 1'b0);

      // Test 1: P=10, D=0, continuous; enable dropped at index 4 of the third period.
      enable = 1'b1;
      tick();
      check("t1_first_busy", busy, 1'b1);
      for (int k = 0; k < 30; k++) begin
         if (k == 24) enable = 1'b0;
         check("t1_tvalid", tvalid, 1'b1);
         check("t1_tdata", tdata, exp_d0[k % 10]);
         check("t1_cycles", cycles_done, k / 10);
         tick();
      end
      check("t1_stop_tvalid", tvalid, 1'b0);
      check("t1_stop_busy", busy, 1'b0);
      check("t1_stop_cycles", cycles_done, 32'd3);
      tick();
      check("t1_idle_tvalid", tvalid, 1'b0);

      // Test 2: P=10, D=3.
      restart(32'd10, 32'd3, 32'd0);
      for (int k = 0; k < 10; k++) begin
         check("t2_tdata", tdata, exp_d3[k]);
         tick();
      end

      // Test 3: backpressure 1,0,1,0; accepted stream must match test 1 and hold while stalled.
      restart(32'd10, 32'd0, 32'd0);
      acc = 0;
      for (int t = 0; t < 40; t++) begin
         tready = (t % 2 == 0);
         check("t3_tvalid", tvalid, 1'b1);
         check("t3_tdata", tdata, exp_d0[acc % 10]);
         tick();
         if (tready) acc++;
      end
      check("t3_cycles", cycles_done, 32'd2);
      tready = 1'b1;

      // Test 4: P=8, three-period burst, enable held high through DONE.
      restart(32'd8, 32'd0, 32'd3);
      acc = 0;
      for (int c = 0; c < 40; c++) begin
         if (tvalid) begin
            check("t4_tdata", tdata, ((acc % 8) < 4) ? W_HH : W_LL);
            acc++;
         end
         tick();
      end
      check("t4_beats", acc, 24);
      check("t4_cycles", cycles_done, 32'd3);
      check("t4_busy", busy, 1'b0);
      check("t4_done_tvalid", tvalid, 1'b0);
      enable = 1'b0;
      tick();
      check("t4_idle_tvalid", tvalid, 1'b0);
      enable = 1'b1;
      tick();
      check("t4_restart_tvalid", tvalid, 1'b1);
      check("t4_restart_busy", busy, 1'b1);
      check("t4_restart_cycles", cycles_done, 32'd0);

      // Test 5a: period 10 -> 6 while index 4 is on the bus.
      restart(32'd10, 32'd0, 32'd0);
      for (int k = 0; k < 10; k++) begin
         if (k == 4) period = 32'd6;
         check("t5a_old_tdata", tdata, exp_d0[k]);
         tick();
      end
      for (int k = 0; k < 12; k++) begin
         check("t5a_new_tdata", tdata, ((k % 6) < 3) ? W_HH : W_LL);
         tick();
      end
      check("t5a_cycles", cycles_done, 32'd3);

      // Test 5b: D=12 with P=8 clamps to D=7.
      restart(32'd8, 32'd12, 32'd0);
      for (int k = 0; k < 16; k++) begin
         check("t5b_tdata", tdata, exp_p8d7[k % 8]);
         tick();
      end

      // Test 5c: P=1 behaves as P=2.
      restart(32'd1, 32'd0, 32'd0);
      for (int k = 0; k < 6; k++) begin
         check("t5c_tdata", tdata, (k % 2 == 0) ? W_HH : W_LL);
         tick();
      end
      check("t5c_cycles", cycles_done, 32'd3);

      // Test 6: reset while stalled mid-period, enable kept high.
      restart(32'd10, 32'd0, 32'd0);
      for (int k = 0; k < 13; k++) tick();
      check("t6_pre_cycles", cycles_done, 32'd1);
      tready = 1'b0;
      tick();
      check("t6_stall_tvalid", tvalid, 1'b1);
      check("t6_stall_tdata", tdata, exp_d0[3]);
      rst = 1'b0;
      tick();
      check("t6_rst_tvalid", tvalid, 1'b0);
      check("t6_rst_cycles", cycles_done, 32'd0);
      check("t6_rst_busy", busy, 1'b0);
      rst = 1'b1;
      tick();
      check("t6_restart_tvalid", tvalid, 1'b1);
      check("t6_restart_busy", busy, 1'b1);
      tready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check("t6_tdata", tdata, exp_d0[k]);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axis_square_stimulus_gen.md
Name: axis_square_stimulus_gen

Overview:
Dual-channel square-wave generator driving an AXI-Stream sample bus in the ADC data format (CH1 low half-word, CH2 high half-word). Period and CH1-to-CH2 delay are programmable in samples. It is the stimulus source for the threshold/reciprocal frequency and phase counter chain, and is used for loopback calibration in place of the ADC.

Parameters:
ADC_WIDTH, 14, sample width per channel (signed).
AXIS_TDATA_WIDTH, 32, stream width; each channel occupies one half.
COUNT_WIDTH, 32, width of the period, delay and cycle counters.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset
enable  input  1  start/continue generation
period  input  COUNT_WIDTH  samples per period P (unsigned)
phase_delay  input  COUNT_WIDTH  CH2 lag behind CH1, in samples D (unsigned)
burst_cycles  input  COUNT_WIDTH  periods to emit; 0 = continuous
level_high_ch1  input  ADC_WIDTH  signed CH1 high level
level_low_ch1  input  ADC_WIDTH  signed CH1 low level
level_high_ch2  input  ADC_WIDTH  signed CH2 high level
level_low_ch2  input  ADC_WIDTH  signed CH2 low level
M_AXIS_OUT_tdata  output  AXIS_TDATA_WIDTH  {sext CH2, sext CH1}; CH1 in [ADC_WIDTH-1:0], CH2 in [AXIS_TDATA_WIDTH/2+ADC_WIDTH-1:AXIS_TDATA_WIDTH/2]; each sign-extended to its half
M_AXIS_OUT_tvalid  output  1  sample valid
M_AXIS_OUT_tready  input  1  downstream accept
busy  output  1  high in RUN
cycles_done  output  COUNT_WIDTH  completed periods since start

Behaviour:
- Reset: state IDLE; tvalid=0; tdata=0; busy=0; cycles_done=0; phase counter=0. Reset mid-operation aborts immediately. The next cycle shows tvalid=0 and is not an AXIS violation because reset overrides.
- States:
  - IDLE: tvalid=0.
  - RUN.
  - DONE: tvalid=0, waits for enable=0.
- IDLE transitions: on enable=1, latch shadow copies of period, phase_delay, burst_cycles and the four levels. Clear cycles_done. Go to RUN. The first sample (index 0) is presented with tvalid=1 on the next edge, so latency is 1 clock from enable sampled high.
- Shadow sanitising:
  - Ps = max(period, 2).
  - Ds = min(phase_delay, Ps-1).
  - H = Ps>>1 (floor).
- Sample k within a period, with index i = 0..Ps-1:
  - CH1 = high_ch1 when i < H, else low_ch1.
  - j = (i >= Ds) ? i-Ds : i+Ps-Ds.
  - CH2 = high_ch2 when j < H, else low_ch2.
- Handshake:
  - tdata/tvalid are registered.
  - The next sample is loaded only when tvalid=0 or tready=1.
  - While tvalid=1 and tready=0, tdata holds stable.
  - No sample is dropped or duplicated.
  - Index i advances only on an accepted beat (tvalid&tready).
- Period wrap: on an accepted beat with i=Ps-1:
  - i returns to 0 and cycles_done increments.
  - Shadows are re-latched from the inputs, so new period/delay/levels take effect only on period boundaries.
  - If burst_cycles_shadow≠0 and cycles_done+1 == burst_cycles_shadow: go to DONE and drop tvalid on the next edge.
  - Else if enable=0: go to IDLE and drop tvalid.
  - Else stay in RUN.
- enable deasserted mid-period: the current period completes fully before stopping.
- DONE to IDLE when enable=0. A re-start requires an enable 0→1 sequence through IDLE.
- cycles_done wraps modulo 2^COUNT_WIDTH in continuous mode.
- busy = (state==RUN).

Optional Feature:
NOISE_EN:
- When defined:
  - Includes a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 at reset, never zero).
  - The LFSR advances once per accepted beat.
  - lfsr[2:0], read as signed (-4..+3), is added to both channels' selected level.
  - The sum saturates to the signed ADC_WIDTH range.
  - Purpose: exercise the counter's hysteresis thresholds.
- When undefined: outputs are exact levels and no LFSR logic exists.

Test Plan:
1. P=10, D=0, CH1/CH2 ±1000, tready=1, enable=1 → per period 5 samples CH1=CH2=+1000 then 5 at -1000; tdata[31:16]=0xFC18 during the low half; cycles_done increments every 10 beats.
2. P=10, D=3 → CH2 high on indices 3..7, low on 8,9,0,1,2; CH2 rising edge 3 samples after CH1's.
3. Same as test 1 with tready pattern 1,0,1,0 → accepted sequence identical to test 1; tdata unchanged across every tready=0 cycle.
4. P=8, burst_cycles=3 → exactly 24 accepted beats, cycles_done=3, busy falls, tvalid=0 in DONE until enable=0.
5. period changed 10→6 at index 4 → the remaining 6 samples of the 10-period complete, then 6-sample periods follow; a separate run with P=8, D=12 behaves as D=7; a run with P=1 behaves as P=2.
6. rst=0 for one cycle while tvalid=1, tready=0 → next cycle tvalid=0, cycles_done=0, busy=0; with enable still high, RUN restarts at index 0 after rst releases.
